fetch_unit: RTL

- Instruction fetch stage that sits directly upstream of the decode/branch logic in the RISC-V processor.
- Owns the architectural PC and drives a req/ack instruction-memory interface.
- Holds the fetched instruction in a one-entry output register with a valid/ready handshake to decode.
- Accepts PC redirects (taken branch/jump) from the branch stage and squashes any wrong-path fetch.

---
 rtl/fetch_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a req/ack instruction-memory port
// and a one-entry valid/ready output register to decode. Option: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int unsigned XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSN  = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_cur
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_misalign
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1
    } state_t;
`endif

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            xfer;
    logic            consume;

    // Request is combinational so a redirect can suppress it in the same cycle
    assign imem_req  = (state == S_RUN) & (~inst_valid | inst_ready) & ~redirect_valid;
    assign imem_addr = pc;
    assign pc_cur    = pc;
    assign xfer      = imem_req & imem_ack;
    assign consume   = inst_valid & inst_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_BOOT;
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            inst_out   <= NOP_INSN;
            inst_pc    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_misalign <= 1'b0;
`endif
        end else begin
            case (state)
                S_BOOT, S_RUN: begin
                    if (state == S_BOOT) begin
                        state <= S_RUN;
                    end
                    // Redirect wins over transfer and consume; it squashes the held word
                    if (redirect_valid) begin
                        inst_valid <= 1'b0;
                        inst_out   <= NOP_INSN;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (redirect_target[1:0] != 2'b00) begin
                            state          <= S_HALT;
                            pc             <= redirect_target;
                            fetch_misalign <= 1'b1;
                        end else begin
                            pc <= redirect_target;
                        end
`else
                        pc <= {redirect_target[XLEN-1:2], 2'b00};
`endif
                    end else if (xfer) begin
                        inst_out   <= imem_rdata;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        pc         <= pc + XLEN'(4);
                    end else if (consume) begin
                        inst_valid <= 1'b0;
                        inst_out   <= NOP_INSN;
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                S_HALT: begin
                    inst_valid <= 1'b0;
                end
`endif
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule
